acc_sequencer: RTL and testbench

Layer sequencer for the convolution accelerator (convolver → relu → pooler). On a start pulse it runs the accelerator once per filter. For each pass it clears the datapath, streams the N×N activation map from a 1-cycle-latency feature-map RAM, enables the datapath until the pooler signals completion, and writes every pooled result to an output buffer at a linear address. It sits between the host/control interface and the accelerator and owns the accelerator's clock-enable, reset and weight-select.

---
 rtl/acc_sequencer_if.sv | 56 +++++
 rtl/acc_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_acc_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_sequencer_if.sv
// rtl/acc_sequencer_if.sv - signal bundle between acc_sequencer and its host, RAM, accelerator and output buffer
//
// Purpose: groups the host control, feature-map RAM read port, accelerator
// control/result signals and output-buffer write port into one interface.
// The sequencer connects through the master modport. The environment side
// (host, RAM, accelerator, buffer) connects through the slave modport.
//
// Signals:
//   start      host -> seq   begin a layer run
//   act_rd     seq  -> RAM   feature-map read strobe
//   act_addr   seq  -> RAM   feature-map read address (AW bits)
//   acc_ce     seq  -> acc   accelerator clock-enable
//   acc_rst    seq  -> acc   accelerator datapath reset, active-high
//   filt_idx   seq  -> acc   weight-bank select (FW bits)
//   acc_valid  acc  -> seq   pooled result valid
//   acc_end    acc  -> seq   pass complete
//   acc_data   acc  -> seq   pooled result (32 bits)
//   out_we     seq  -> buf   output buffer write enable
//   out_addr   seq  -> buf   output buffer address (OW bits)
//   out_data   seq  -> buf   output buffer write data (32 bits)
//   busy       seq  -> host  run in progress
//   done       seq  -> host  one-cycle end-of-run pulse
//   err        seq  -> host  sticky error flag
interface acc_sequencer_if #(
   parameter int AW = 7,
   parameter int OW = 6,
   parameter int FW = 2
);
   logic          start;
   logic          act_rd;
   logic [AW-1:0] act_addr;
   logic          acc_ce;
   logic          acc_rst;
   logic [FW-1:0] filt_idx;
   logic          acc_valid;
   logic          acc_end;
   logic [31:0]   acc_data;
   logic          out_we;
   logic [OW-1:0] out_addr;
   logic [31:0]   out_data;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      input  start, acc_valid, acc_end, acc_data,
      output act_rd, act_addr, acc_ce, acc_rst, filt_idx,
             out_we, out_addr, out_data, busy, done, err
   );

   modport slave (
      output start, acc_valid, acc_end, acc_data,
      input  act_rd, act_addr, acc_ce, acc_rst, filt_idx,
             out_we, out_addr, out_data, busy, done, err
   );
endinterface

// File: rtl/acc_sequencer.sv
// rtl/acc_sequencer.sv - layer sequencer running the conv/relu/pool accelerator once per filter
//
// Purpose: on an accepted start, runs NUM_FILTERS passes. Each pass does the
// following in order:
//   - clears the datapath (2 cycles, acc_rst high);
//   - streams the N*N activation map from a 1-cycle-latency RAM;
//   - keeps the datapath enabled until acc_end arrives;
//   - writes each pooled result to the output buffer at
//     filt_idx*OPF + out_cnt.
// The run ends with a one-cycle done pulse. Protocol problems set the
// sticky err flag: too many results, too few results, or a drain timeout.
//
// Ports:
//   clk         rising-edge clock
//   global_rst  synchronous active-low reset (also forces acc_rst high directly)
//   bus         acc_sequencer_if master modport (see interface for signal list)
module acc_sequencer #(
   parameter int N           = 10,
   parameter int K           = 3,
   parameter int P           = 2,
   parameter int NUM_FILTERS = 4,
   parameter int TIMEOUT     = 256
) (
   input  logic            clk,
   input  logic            global_rst,
   acc_sequencer_if.master bus
);
   localparam int NPIX = N * N;
   localparam int OPF  = ((N - K + 1) / P) * ((N - K + 1) / P);
   localparam int AW   = $clog2(NPIX);
   localparam int OW   = $clog2(NUM_FILTERS * OPF);
   localparam int FW   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
   // out_cnt must be able to hold OPF itself so that an extra result is detectable
   localparam int CW   = $clog2(OPF + 1);
   localparam int TW   = $clog2(TIMEOUT + 1);

   localparam logic [AW-1:0] LAST_PIX  = AW'(NPIX - 1);
   localparam logic [FW-1:0] LAST_FILT = FW'(NUM_FILTERS - 1);
   localparam logic [CW-1:0] OPF_C     = CW'(OPF);
   localparam logic [TW-1:0] TMO_C     = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_DRAIN,
      S_NEXT,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic          clr_cnt_q, clr_cnt_d;
   logic [AW-1:0] pix_cnt_q, pix_cnt_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [FW-1:0] filt_idx_q, filt_idx_d;
   logic          err_q, err_d;
   logic          acc_ce_q, acc_ce_d;
   logic          acc_rst_q, acc_rst_d;
   logic          capture;
   logic          out_we_c;
   logic [OW-1:0] out_addr_c;

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = 1'b0;
      pix_cnt_d  = pix_cnt_q;
      out_cnt_d  = out_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      filt_idx_d = filt_idx_q;
      err_d      = err_q;
      out_we_c   = 1'b0;
      out_addr_c = OW'(32'(filt_idx_q) * OPF + 32'(out_cnt_q));

      // Results are accepted only while the datapath is live (STREAM/DRAIN).
      // The write is a same-cycle pass-through of acc_valid. A result beyond
      // OPF is dropped rather than spilling into the next filter's region.
      capture = (state_q == S_STREAM) || (state_q == S_DRAIN);
      if (capture && bus.acc_valid) begin
         if (out_cnt_q != OPF_C) begin
            out_we_c  = 1'b1;
            out_cnt_d = out_cnt_q + 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_CLEAR;
               filt_idx_d = '0;
               err_d      = 1'b0;
            end
         end
         S_CLEAR: begin
            pix_cnt_d = '0;
            out_cnt_d = '0;
            tmo_cnt_d = '0;
            if (clr_cnt_q) begin
               state_d = S_STREAM;
            end else begin
               clr_cnt_d = 1'b1;
            end
         end
         S_STREAM: begin
            // Hold the address at the last pixel so act_addr does not wrap.
            if (pix_cnt_q == LAST_PIX) begin
               state_d = S_DRAIN;
            end else begin
               pix_cnt_d = pix_cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            // acc_end wins over a timeout landing in the same cycle.
            if (bus.acc_end) begin
               state_d = S_NEXT;
            end else if (tmo_cnt_d == TMO_C) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_NEXT: begin
            if (out_cnt_q != OPF_C) begin
               err_d = 1'b1;
            end
            if (filt_idx_q == LAST_FILT) begin
               state_d = S_DONE;
            end else begin
               filt_idx_d = filt_idx_q + 1'b1;
               state_d    = S_CLEAR;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // RAM data lags act_rd by one cycle, so the datapath is enabled one
      // cycle after each read. It then stays enabled for the whole drain.
      acc_ce_d  = (state_q == S_STREAM) || (state_d == S_DRAIN);
      acc_rst_d = (state_d == S_CLEAR);
   end

   always_ff @(posedge clk) begin
      if (!global_rst) begin
         state_q    <= S_IDLE;
         clr_cnt_q  <= 1'b0;
         pix_cnt_q  <= '0;
         out_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         filt_idx_q <= '0;
         err_q      <= 1'b0;
         acc_ce_q   <= 1'b0;
         acc_rst_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         pix_cnt_q  <= pix_cnt_d;
         out_cnt_q  <= out_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         filt_idx_q <= filt_idx_d;
         err_q      <= err_d;
         acc_ce_q   <= acc_ce_d;
         acc_rst_q  <= acc_rst_d;
      end
   end

   assign bus.act_rd   = (state_q == S_STREAM);
   assign bus.act_addr = pix_cnt_q;
   assign bus.acc_ce   = acc_ce_q;
   // The datapath is held in reset together with the sequencer, without
   // waiting for a clock edge.
   assign bus.acc_rst  = acc_rst_q | ~global_rst;
   assign bus.filt_idx = filt_idx_q;
   assign bus.out_we   = out_we_c;
   assign bus.out_addr = out_addr_c;
   assign bus.out_data = bus.acc_data;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.err      = err_q;
endmodule

// File: tb/tb_acc_sequencer.sv
// tb/tb_acc_sequencer.sv - self-checking bench for acc_sequencer (default layer plus a single-filter instance)
//
// Purpose: drives start, acc_valid, acc_end and acc_data. The expected
// per-cycle outputs are derived from a per-pass timeline: each pass is
// CLEAR(2) + STREAM(N*N) + DRAIN(d) + NEXT(1), with results counted per pass.
// No ports: top-level bench.
module tb_acc_sequencer;
   localparam int N    = 10;
   localparam int K    = 3;
   localparam int P    = 2;
   localparam int NF   = 4;
   localparam int TMO  = 256;
   localparam int NPIX = N * N;
   localparam int OPF  = ((N - K + 1) / P) * ((N - K + 1) / P);
   localparam int AW   = $clog2(NPIX);
   localparam int OW   = $clog2(NF * OPF);
   localparam int FW   = (NF > 1) ? $clog2(NF) : 1;
   localparam int OW1  = $clog2(OPF);
   localparam int BIG  = 1 << 30;

   logic        clk = 1'b0;
   logic        global_rst;
   logic        start;
   logic        acc_valid;
   logic        acc_end;
   logic [31:0] acc_data;

   acc_sequencer_if #(.AW(AW), .OW(OW),  .FW(FW)) bus  ();
   acc_sequencer_if #(.AW(AW), .OW(OW1), .FW(1))  bus1 ();

   assign bus.start      = start;
   assign bus.acc_valid  = acc_valid;
   assign bus.acc_end    = acc_end;
   assign bus.acc_data   = acc_data;
   assign bus1.start     = start;
   assign bus1.acc_valid = acc_valid;
   assign bus1.acc_end   = acc_end;
   assign bus1.acc_data  = acc_data;

   acc_sequencer #(.N(N), .K(K), .P(P), .NUM_FILTERS(NF), .TIMEOUT(TMO)) u_dut (
      .clk        (clk),
      .global_rst (global_rst),
      .bus        (bus)
   );

   acc_sequencer #(.N(N), .K(K), .P(P), .NUM_FILTERS(1), .TIMEOUT(TMO)) u_dut1 (
      .clk        (clk),
      .global_rst (global_rst),
      .bus        (bus1)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int tcur  = -1;

   // per-run configuration
   int nv[NF];
   int to_pass;
   int inj_t;
   bit chk1;
   bit err_prev;

   // per-run timeline
   int base[NF];
   int eoff[NF];
   int dend[NF];
   int vpos[NF][20];
   int nfp;
   int t_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, tcur, obs, exp);
      end
   endtask

   task automatic run_layer(input bit cov);
      int   t, f, off, pos, t_done1, n_done1, err_from, e_addr;
      int   ptr[NF];
      int   cnt[NF];
      bit   seen[NF*OPF];
      logic v_real, e_busy, e_done, e_rst, e_rd, e_ce, e_we, e_err;

      for (int i = 0; i < NF; i++) begin
         ptr[i] = 0;
         cnt[i] = 0;
      end
      for (int i = 0; i < NF * OPF; i++) seen[i] = 1'b0;
      n_done1  = 0;
      err_from = BIG;

      // plan: pass base cycle, result positions, acc_end offset, drain end
      t   = 1;
      nfp = NF;
      for (int p = 0; p < NF; p++) begin
         base[p] = t;
         pos = NPIX - 40 + int'($urandom_range(0, 3));
         for (int k = 0; k < nv[p]; k++) begin
            vpos[p][k] = pos;
            pos += 1 + int'($urandom_range(0, 3));
         end
         if (p == to_pass) begin
            eoff[p] = -1;
            dend[p] = NPIX + 1 + TMO;
            t_done  = base[p] + dend[p] + 1;
            err_from = t_done;
            nfp     = p + 1;
            break;
         end
         eoff[p] = vpos[p][nv[p]-1] + int'($urandom_range(0, 2));
         if (eoff[p] < NPIX + 2) eoff[p] = NPIX + 2;
         dend[p] = eoff[p];
         t = base[p] + eoff[p] + 2;
      end
      if (to_pass < 0) t_done = t;
      t_done1 = base[0] + eoff[0] + 2;

      for (t = 0; t <= t_done + 2; t++) begin
         @(negedge clk);
         tcur = t;
         f    = -1;
         off  = 0;
         if (t >= 1 && t < t_done) begin
            for (int i = 0; i < nfp; i++) if (t >= base[i]) f = i;
         end
         if (f >= 0) off = t - base[f];

         start     = (t == 0) || (t == inj_t) || (t == t_done);
         acc_valid = 1'b0;
         acc_end   = 1'b0;
         acc_data  = $urandom;
         v_real    = 1'b0;
         if (f >= 0 && off >= 2 && off <= dend[f]) begin
            if (ptr[f] < nv[f] && vpos[f][ptr[f]] == off) begin
               acc_valid = 1'b1;
               v_real    = 1'b1;
               ptr[f]++;
            end
            acc_end = (off == eoff[f]);
         end else if (t >= 1) begin
            // noise in phases where the accelerator must be ignored
            acc_valid = 1'($urandom_range(0, 1));
            acc_end   = 1'($urandom_range(0, 1));
         end
         #1;

         e_busy = (t >= 1) && (t <= t_done);
         e_done = (t == t_done);
         e_rst  = (f >= 0) && (off < 2);
         e_rd   = (f >= 0) && (off >= 2) && (off <= NPIX + 1);
         e_ce   = (f >= 0) && (off >= 3) && (off <= dend[f]);
         e_we   = 1'b0;
         e_addr = 0;
         if (v_real) begin
            if (cnt[f] < OPF) begin
               e_we   = 1'b1;
               e_addr = f * OPF + cnt[f];
               cnt[f]++;
            end else if (err_from > t + 1) begin
               err_from = t + 1;
            end
         end
         if (f >= 0 && eoff[f] >= 0 && off == eoff[f] + 1 && cnt[f] != OPF && err_from > t + 1)
            err_from = t + 1;
         e_err = (t == 0) ? err_prev : (t >= err_from);

         chk("busy",    bus.busy,    e_busy);
         chk("done",    bus.done,    e_done);
         chk("acc_rst", bus.acc_rst, e_rst);
         chk("act_rd",  bus.act_rd,  e_rd);
         chk("acc_ce",  bus.acc_ce,  e_ce);
         chk("out_we",  bus.out_we,  e_we);
         chk("err",     bus.err,     e_err);
         if (e_rd)   chk("act_addr", bus.act_addr, off - 2);
         if (f >= 0) chk("filt_idx", bus.filt_idx, f);
         if (e_we) begin
            chk("out_addr", bus.out_addr, e_addr);
            chk("out_data", bus.out_data, acc_data);
         end
         if (bus.out_we === 1'b1) seen[bus.out_addr] = 1'b1;

         if (chk1 && t >= 1 && t <= t_done1 + 1) begin
            chk("d1_busy", bus1.busy, t <= t_done1);
            chk("d1_done", bus1.done, t == t_done1);
            chk("d1_err",  bus1.err,  0);
            if (t < t_done1) begin
               chk("d1_act_rd",  bus1.act_rd,  e_rd);
               chk("d1_acc_ce",  bus1.acc_ce,  e_ce);
               chk("d1_acc_rst", bus1.acc_rst, e_rst);
               chk("d1_out_we",  bus1.out_we,  e_we);
               if (e_rd) chk("d1_act_addr", bus1.act_addr, off - 2);
               if (e_we) chk("d1_out_addr", bus1.out_addr, e_addr);
            end else begin
               chk("d1_out_we", bus1.out_we, 0);
            end
         end
         if (chk1 && t < t_done && bus1.done === 1'b1) n_done1++;
      end

      start     = 1'b0;
      acc_valid = 1'b0;
      acc_end   = 1'b0;
      if (chk1) chk("d1_done_count", n_done1, 1);
      if (cov) begin
         for (int i = 0; i < NF * OPF; i++) chk("out_cover", seen[i], 1);
      end
      err_prev = (err_from <= t_done);
   endtask

   initial begin
      bit done_seen;

      // reset held with start and accelerator noise active
      global_rst = 1'b0;
      start      = 1'b1;
      acc_valid  = 1'b1;
      acc_end    = 1'b1;
      acc_data   = 32'h1234_5678;
      err_prev   = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("rst_busy",     bus.busy,     0);
         chk("rst_done",     bus.done,     0);
         chk("rst_act_rd",   bus.act_rd,   0);
         chk("rst_act_addr", bus.act_addr, 0);
         chk("rst_acc_ce",   bus.acc_ce,   0);
         chk("rst_out_we",   bus.out_we,   0);
         chk("rst_acc_rst",  bus.acc_rst,  1);
         chk("rst_err",      bus.err,      0);
         chk("rst_d1_busy",  bus1.busy,    0);
      end
      @(negedge clk);
      global_rst = 1'b1;
      start      = 1'b0;
      acc_valid  = 1'b0;
      acc_end    = 1'b0;
      #1;
      chk("idle_acc_rst", bus.acc_rst, 0);
      chk("idle_busy",    bus.busy,    0);

      // full clean layer, single-filter instance checked alongside, start during STREAM
      for (int i = 0; i < NF; i++) nv[i] = OPF;
      to_pass = -1;
      inj_t   = 50;
      chk1    = 1'b1;
      run_layer(1'b1);

      // drain timeout in pass 0
      chk1    = 1'b0;
      inj_t   = -1;
      to_pass = 0;
      run_layer(1'b0);

      // one extra result in pass 1
      to_pass = -1;
      nv[1]   = OPF + 1;
      run_layer(1'b0);

      // one result short in pass 2
      nv[1] = OPF;
      nv[2] = OPF - 1;
      run_layer(1'b0);

      // reset in the middle of DRAIN
      tcur = -2;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (NPIX + 6) @(negedge clk);
      #1;
      chk("mid_in_drain", bus.acc_ce, 1);
      global_rst = 1'b0;
      acc_valid  = 1'b1;
      #1;
      chk("mid_acc_rst_comb", bus.acc_rst, 1);
      @(negedge clk);
      #1;
      chk("mid_busy",     bus.busy,     0);
      chk("mid_done",     bus.done,     0);
      chk("mid_act_rd",   bus.act_rd,   0);
      chk("mid_act_addr", bus.act_addr, 0);
      chk("mid_acc_ce",   bus.acc_ce,   0);
      chk("mid_out_we",   bus.out_we,   0);
      chk("mid_err",      bus.err,      0);
      chk("mid_acc_rst",  bus.acc_rst,  1);
      global_rst = 1'b1;
      acc_valid  = 1'b0;
      done_seen  = 1'b0;
      repeat (TMO + 50) begin
         @(negedge clk);
         if (bus.done !== 1'b0) done_seen = 1'b1;
      end
      chk("mid_no_done",    done_seen, 0);
      chk("mid_final_busy", bus.busy,  0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
